carry_increment_adder_pipe: RTL and testbench

Parametrised, pipelined carry-increment adder. It computes in1 + in2 + cin over N bits, split into BLOCK-bit ripple segments. It uses a 2-stage pipeline with valid/ready handshaking and full backpressure, and is the next generation of the team's combinational two-half carry-increment adder. It is intended as the registered adder datapath element in the VLSI timing and area comparisons.

---
 rtl/carry_increment_adder_pipe.sv | 124 ++++++++++++
 tb/tb_carry_increment_adder_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_increment_adder_pipe.sv
// Two-stage pipelined carry-increment adder: sum = in1 + in2 + cin over N bits, BLOCK-bit segments.
// Optional signed-overflow output ovf is enabled by defining CIA_PIPE_OVF_EN.
module carry_increment_adder_pipe #(
   parameter int N     = 32,
   parameter int BLOCK = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in1,
   input  logic [N-1:0] in2,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   sum
`ifdef CIA_PIPE_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int NB = N / BLOCK;

   generate
      if ((BLOCK < 1) || (BLOCK > N) || ((N % BLOCK) != 0)) begin : g_bad_param
         $error("carry_increment_adder_pipe: N must be a positive multiple of BLOCK");
      end
   endgenerate

   logic          w_s2_adv;
   logic          w_s1_adv;
   logic          r_s1_valid;
   logic [N-1:0]  r_s1_sum;
   logic [NB-1:0] r_s1_g;
   logic [N-1:0]  w_s1_sum;
   logic [NB-1:0] w_s1_g;
   logic [BLOCK:0] w_seg;
   logic [N-1:0]  w_s2_sum;
   logic [BLOCK:0] w_inc;
   logic          w_carry;
   logic          w_s2_cout;

   assign w_s2_adv = !out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // Independent segment ripple sums; only segment 0 sees the external carry-in.
   always_comb begin
      w_s1_sum = '0;
      w_s1_g   = '0;
      w_seg    = '0;
      for (int k = 0; k < NB; k++) begin
         w_seg = {1'b0, in1[k*BLOCK +: BLOCK]} + {1'b0, in2[k*BLOCK +: BLOCK]}
               + ((k == 0) ? {{BLOCK{1'b0}}, cin} : {(BLOCK+1){1'b0}});
         w_s1_sum[k*BLOCK +: BLOCK] = w_seg[BLOCK-1:0];
         w_s1_g[k]                  = w_seg[BLOCK];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_g     <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sum <= w_s1_sum;
            r_s1_g   <= w_s1_g;
         end
      end
   end

   // Increment chain: each segment absorbs the carry of the one below it.
   always_comb begin
      w_s2_sum = r_s1_sum;
      w_carry  = r_s1_g[0];
      w_inc    = '0;
      for (int k = 1; k < NB; k++) begin
         w_inc = {1'b0, r_s1_sum[k*BLOCK +: BLOCK]} + {{BLOCK{1'b0}}, w_carry};
         w_s2_sum[k*BLOCK +: BLOCK] = w_inc[BLOCK-1:0];
         w_carry = r_s1_g[k] | w_inc[BLOCK];
      end
      w_s2_cout = w_carry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
      end else if (w_s2_adv) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            sum <= {w_s2_cout, w_s2_sum};
         end
      end
   end

`ifdef CIA_PIPE_OVF_EN
   // Carry into the MSB is recovered as a^b^s at bit N-1, so only a^b is carried through S1.
   logic r_s1_axb_msb;
   logic w_ovf;

   assign w_ovf = (r_s1_axb_msb ^ w_s2_sum[N-1]) ^ w_s2_cout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_axb_msb <= 1'b0;
      end else if (w_s1_adv && in_valid) begin
         r_s1_axb_msb <= in1[N-1] ^ in2[N-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (w_s2_adv && r_s1_valid) begin
         ovf <= w_ovf;
      end
   end
`endif

endmodule

// File: tb/tb_carry_increment_adder_pipe.sv
// Directed bench for carry_increment_adder_pipe with an arithmetic reference model and queue scoreboard.
module tb_carry_increment_adder_pipe;

   localparam int N     = 32;
   localparam int BLOCK = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in1;
   logic [N-1:0] in2;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [N:0]   sum;
`ifdef CIA_PIPE_OVF_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [N+1:0] exp_q[$];

   carry_increment_adder_pipe #(.N(N), .BLOCK(BLOCK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
`ifdef CIA_PIPE_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition plus sign-rule overflow, {ovf, sum}.
   function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      logic [N:0] s;
      logic       v;
      s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
      v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
      return {v, s};
   endfunction

   // Scoreboard: inputs change just after posedge, so negedge sees the values the next edge will use.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL spurious_out: got out_valid=1 sum=0x%0h, expected no output", sum);
            end else begin
               check("model_sum", 64'(sum), 64'(exp_q[0][N:0]));
`ifdef CIA_PIPE_OVF_EN
               check("model_ovf", 64'(ovf), 64'(exp_q[0][N+1]));
`endif
               if (out_ready) begin
                  void'(exp_q.pop_front());
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in1, in2, cin));
         end
      end
   end

   task automatic send_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                           input logic [N:0] exp_sum, input logic exp_ovf, input string name);
      logic [N+1:0] m;
      m = model(a, b, c);
      check({name, "_model"}, 64'(m), 64'({exp_ovf, exp_sum}));
      in1 = a; in2 = b; cin = c; in_valid = 1'b1;
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check({name, "_valid"}, 64'(out_valid), 64'd1);
      check({name, "_sum"}, 64'(sum), 64'(exp_sum));
`ifdef CIA_PIPE_OVF_EN
      check({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
   endtask

   task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b);
      in1 = a; in2 = b; cin = 1'b0; in_valid = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; cin = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_valid", 64'(out_valid), 64'd0);
      check("rst_hold_sum", 64'(sum), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_rel_valid", 64'(out_valid), 64'd0);
      check("rst_rel_sum", 64'(sum), 64'd0);
      check("rst_rel_in_ready", 64'(in_ready), 64'd1);

      send_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 1'b0, "full_carry");
      send_one(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 33'h0_0100_0000, 1'b0, "inc_segs");
      send_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1, "pos_ovf");
      send_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF, 1'b0, "all_ones");
      send_one(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1, "neg_ovf");
      send_one(32'h1234_5678, 32'h0EDC_BA98, 1'b0, 33'h0_2111_1110, 1'b0, "mixed");
      send_one(32'h0000_00FF, 32'h0000_0000, 1'b1, 33'h0_0000_0100, 1'b0, "seg0_carry");

      // Streaming at one beat per cycle.
      @(posedge clk); #1;
      drive(32'd1, 32'd2);
      @(posedge clk); #1;
      drive(32'd3, 32'd4);
      @(posedge clk); #1;
      drive(32'd5, 32'd6);
      check("stream0_valid", 64'(out_valid), 64'd1);
      check("stream0_sum", 64'(sum), 64'd3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("stream1_sum", 64'(sum), 64'd7);
      @(posedge clk); #1;
      check("stream2_valid", 64'(out_valid), 64'd1);
      check("stream2_sum", 64'(sum), 64'd11);
      @(posedge clk); #1;
      check("stream_end_valid", 64'(out_valid), 64'd0);

      // Backpressure: two beats fill the pipe, the third waits.
      out_ready = 1'b0;
      drive(32'h10, 32'h01);
      #1;
      check("bp_ready0", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      drive(32'h20, 32'h02);
      check("bp_ready1", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      drive(32'h30, 32'h03);
      check("bp_full_ready", 64'(in_ready), 64'd0);
      check("bp_full_sum", 64'(sum), 64'h11);
      @(posedge clk); #1;
      check("bp_hold_ready", 64'(in_ready), 64'd0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_sum", 64'(sum), 64'h11);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_out2_sum", 64'(sum), 64'h22);
      @(posedge clk); #1;
      check("bp_out3_sum", 64'(sum), 64'h33);
      @(posedge clk); #1;
      check("bp_end_valid", 64'(out_valid), 64'd0);

      // Asynchronous reset with two beats in flight.
      out_ready = 1'b0;
      drive(32'h40, 32'h04);
      @(posedge clk); #1;
      drive(32'h50, 32'h05);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid_inflight_valid", 64'(out_valid), 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("post_rst_idle", 64'(out_valid), 64'd0);
      end
      send_one(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002, 1'b0, "post_rst");

      repeat (3) @(posedge clk);
      #1;
      check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
